vga_timing_gen: RTL and testbench

- Generates the 640x480 @ 60 Hz raster timing consumed by the image mappers: DrawX, DrawY, blank (1 = active video), and active-low hs/vs.
- Adds a configurable delay line on hs/vs/blank so the sync outputs line up with mapper pixel data. Mapper pixel data trails DrawX/DrawY by ROM latency plus the colour register.
- Sits between the top-level clock source and every *_mapper instance and the VGA pins.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: position counters, zero-skew registered sync/blank decode,
// and a short delay line that aligns hs_d/vs_d/blank_d with mapper pixel data.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_start,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       blank_next;
  logic       hs_next;
  logic       vs_next;

  // NOTE: defaults first so every path assigns x_next/y_next and no latch is inferred.
  always_comb begin
    x_next = DrawX + 10'd1;
    y_next = DrawY;
    if (DrawX == X_LAST) begin
      x_next = '0;
      y_next = (DrawY == Y_LAST) ? '0 : DrawY + 10'd1;
    end
  end

  // Decoding the next position lets the registered flags land in the same cycle as the counters.
  assign blank_next = (x_next < X_VIS) && (y_next < Y_VIS);
  assign hs_next    = !((x_next >= HS_START) && (x_next < HS_END));
  assign vs_next    = !((y_next >= VS_START) && (y_next < VS_END));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= X_LAST;
      DrawY       <= Y_LAST;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      DrawX       <= x_next;
      DrawY       <= y_next;
      blank       <= blank_next;
      hs          <= hs_next;
      vs          <= vs_next;
      frame_start <= (x_next == '0) && (y_next == '0);
      line_start  <= (x_next == '0);
    end
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs_d    = hs;
      assign vs_d    = vs;
      assign blank_d = blank;
    end else begin : g_delay
      sync_t pipe [SYNC_DELAY];

      // NOTE: the stages are reset so the delayed syncs idle inactive until real history arrives.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_DELAY; i++) pipe[i] <= SYNC_IDLE;
        end else begin
          pipe[0] <= {hs, vs, blank};
          for (int i = 1; i < SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign hs_d    = pipe[SYNC_DELAY-1].hs;
      assign vs_d    = pipe[SYNC_DELAY-1].vs;
      assign blank_d = pipe[SYNC_DELAY-1].blank;
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus two shrunken rasters (delay 3 and 0),
// all compared against an arithmetic raster model indexed by cycles since reset release.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    logic       line_start;
    logic       hs_d;
    logic       vs_d;
    logic       blank_d;
  } view_t;

  typedef struct packed {
    int h_vis; int h_fp; int h_sync; int h_bp;
    int v_vis; int v_fp; int v_sync; int v_bp;
    int delay;
  } timing_t;

  localparam timing_t TA = '{h_vis:640, h_fp:16, h_sync:96, h_bp:48,
                             v_vis:480, v_fp:10, v_sync:2, v_bp:33, delay:2};
  localparam timing_t TB = '{h_vis:20, h_fp:4, h_sync:6, h_bp:5,
                             v_vis:12, v_fp:3, v_sync:2, v_bp:4, delay:3};
  localparam timing_t TC = '{h_vis:20, h_fp:4, h_sync:6, h_bp:5,
                             v_vis:12, v_fp:3, v_sync:2, v_bp:4, delay:0};

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic bl_a, hs_a, vs_a, fs_a, ls_a, hsd_a, vsd_a, bld_a;
  logic bl_b, hs_b, vs_b, fs_b, ls_b, hsd_b, vsd_b, bld_b;
  logic bl_c, hs_c, vs_c, fs_c, ls_c, hsd_c, vsd_c, bld_c;

  view_t obs_a, obs_b, obs_c;
  assign obs_a = {x_a, y_a, bl_a, hs_a, vs_a, fs_a, ls_a, hsd_a, vsd_a, bld_a};
  assign obs_b = {x_b, y_b, bl_b, hs_b, vs_b, fs_b, ls_b, hsd_b, vsd_b, bld_b};
  assign obs_c = {x_c, y_c, bl_c, hs_c, vs_c, fs_c, ls_c, hsd_c, vsd_c, bld_c};

  vga_timing_gen dut_a (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x_a), .DrawY(y_a), .blank(bl_a),
    .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .line_start(ls_a),
    .hs_d(hsd_a), .vs_d(vsd_a), .blank_d(bld_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(TB.h_vis), .H_FP(TB.h_fp), .H_SYNC(TB.h_sync), .H_BP(TB.h_bp),
    .V_VISIBLE(TB.v_vis), .V_FP(TB.v_fp), .V_SYNC(TB.v_sync), .V_BP(TB.v_bp),
    .SYNC_DELAY(TB.delay)
  ) dut_b (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x_b), .DrawY(y_b), .blank(bl_b),
    .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .line_start(ls_b),
    .hs_d(hsd_b), .vs_d(vsd_b), .blank_d(bld_b)
  );

  vga_timing_gen #(
    .H_VISIBLE(TC.h_vis), .H_FP(TC.h_fp), .H_SYNC(TC.h_sync), .H_BP(TC.h_bp),
    .V_VISIBLE(TC.v_vis), .V_FP(TC.v_fp), .V_SYNC(TC.v_sync), .V_BP(TC.v_bp),
    .SYNC_DELAY(TC.delay)
  ) dut_c (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x_c), .DrawY(y_c), .blank(bl_c),
    .hs(hs_c), .vs(vs_c), .frame_start(fs_c), .line_start(ls_c),
    .hs_d(hsd_c), .vs_d(vsd_c), .blank_d(bld_c)
  );

  always #5 vga_clk = ~vga_clk;

  // Cycles elapsed since reset release; -1 while in reset.
  longint t = -1;
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) t <= -1;
    else          t <= t + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Raster state at cycle t: the reset state is position (H_TOTAL-1, V_TOTAL-1), i.e. t = -1.
  function automatic view_t raster(input longint tt, input timing_t p);
    longint ht, vt, f, pos, x, y;
    view_t v;
    ht  = longint'(p.h_vis + p.h_fp + p.h_sync + p.h_bp);
    vt  = longint'(p.v_vis + p.v_fp + p.v_sync + p.v_bp);
    f   = ht * vt;
    pos = ((tt % f) + f) % f;
    x   = pos % ht;
    y   = pos / ht;
    v = '0;
    v.x           = 10'(x);
    v.y           = 10'(y);
    v.blank       = (x < p.h_vis) && (y < p.v_vis);
    v.hs          = !((x >= p.h_vis + p.h_fp) && (x < p.h_vis + p.h_fp + p.h_sync));
    v.vs          = !((y >= p.v_vis + p.v_fp) && (y < p.v_vis + p.v_fp + p.v_sync));
    v.frame_start = (x == 0) && (y == 0);
    v.line_start  = (x == 0);
    return v;
  endfunction

  function automatic view_t model(input longint tt, input timing_t p);
    view_t  v, d;
    longint td;
    v  = raster(tt, p);
    td = tt - p.delay;
    if (td < -1) td = -1;
    d  = raster(td, p);
    v.hs_d    = d.hs;
    v.vs_d    = d.vs;
    v.blank_d = d.blank;
    return v;
  endfunction

  function automatic string fmt(input view_t v);
    return $sformatf("x=%0d y=%0d bl=%b hs=%b vs=%b fs=%b ls=%b hsd=%b vsd=%b bld=%b",
                     v.x, v.y, v.blank, v.hs, v.vs, v.frame_start, v.line_start,
                     v.hs_d, v.vs_d, v.blank_d);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) begin
      @(negedge vga_clk);
      n_cmp++;
      if (obs_a !== model(t, TA)) begin
        n_fail++; $display("FAIL reset_a: got %s want %s", fmt(obs_a), fmt(model(t, TA)));
      end
      n_cmp++;
      if (x_a !== 10'd799 || y_a !== 10'd524 || hs_a !== 1'b1 || vs_a !== 1'b1 ||
          bl_a !== 1'b0 || fs_a !== 1'b0 || ls_a !== 1'b0) begin
        n_fail++; $display("FAIL reset_const_a: got %s want x=799 y=524 hs=vs=1 bl=fs=ls=0", fmt(obs_a));
      end
      n_cmp++;
      if (obs_b !== model(t, TB) || obs_c !== model(t, TC)) begin
        n_fail++; $display("FAIL reset_bc: got %s / %s want %s", fmt(obs_b), fmt(obs_c), fmt(model(t, TB)));
      end
    end
    reset_n = 1'b1;
    @(negedge vga_clk);
    n_cmp++;
    if (x_a !== 10'd0 || y_a !== 10'd0 || bl_a !== 1'b1 || fs_a !== 1'b1 || ls_a !== 1'b1 ||
        hsd_a !== 1'b1 || vsd_a !== 1'b1 || bld_a !== 1'b0) begin
      n_fail++; $display("FAIL release_edge1: got %s want x=0 y=0 bl=fs=ls=1 hsd=vsd=1 bld=0", fmt(obs_a));
    end
    @(negedge vga_clk);
    n_cmp++;
    if (x_a !== 10'd1 || fs_a !== 1'b0 || ls_a !== 1'b0 || hsd_a !== 1'b1 || vsd_a !== 1'b1 || bld_a !== 1'b0) begin
      n_fail++; $display("FAIL release_edge2: got %s want x=1 fs=ls=0 hsd=vsd=1 bld=0", fmt(obs_a));
    end
    @(negedge vga_clk);
    n_cmp++;
    if (bld_a !== 1'b1 || x_a !== 10'd2) begin
      n_fail++; $display("FAIL release_edge3: got %s want x=2 bld=1", fmt(obs_a));
    end
    n_cmp++;
    if (obs_b !== model(t, TB) || obs_c !== model(t, TC)) begin
      n_fail++; $display("FAIL release_bc: got %s / %s want %s / %s",
                         fmt(obs_b), fmt(obs_c), fmt(model(t, TB)), fmt(model(t, TC)));
    end
  endtask

  task automatic test_line_wrap();
    int budget = 0;
    while (!(x_a == 10'd799 && y_a == 10'd10) && budget < 20000) begin
      @(negedge vga_clk);
      budget++;
    end
    n_cmp++;
    if (budget >= 20000) begin
      n_fail++; $display("FAIL line_wrap_reach: got %s want x=799 y=10 within budget", fmt(obs_a));
    end
    @(negedge vga_clk);
    n_cmp++;
    if (x_a !== 10'd0 || y_a !== 10'd11 || ls_a !== 1'b1 || fs_a !== 1'b0 || bl_a !== 1'b1) begin
      n_fail++; $display("FAIL line_wrap_edge: got %s want x=0 y=11 ls=1 fs=0 bl=1", fmt(obs_a));
    end
    for (int i = 0; i < 800; i++) begin
      @(negedge vga_clk);
      n_cmp++;
      if (obs_a !== model(t, TA)) begin
        n_fail++; $display("FAIL line_wrap_model: got %s want %s", fmt(obs_a), fmt(model(t, TA)));
      end
      if (x_a == 10'd640) begin
        n_cmp++;
        if (bl_a !== 1'b0) begin
          n_fail++; $display("FAIL blank_at_640: got bl=%b want 0", bl_a);
        end
      end
      if (x_a == 10'd0) begin
        n_cmp++;
        if (bl_a !== 1'b1) begin
          n_fail++; $display("FAIL blank_at_0: got bl=%b want 1", bl_a);
        end
      end
    end
  endtask

  task automatic test_hsync();
    int low_cnt = 0;
    int first_low = -1;
    int first_high = -1;
    int budget = 0;
    while (x_a != 10'd0 && budget < 1000) begin
      @(negedge vga_clk);
      budget++;
    end
    for (int i = 0; i < 800; i++) begin
      if (hs_a === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(x_a);
      end else if (first_low >= 0 && first_high < 0) begin
        first_high = int'(x_a);
      end
      @(negedge vga_clk);
    end
    n_cmp++;
    if (low_cnt != 96) begin
      n_fail++; $display("FAIL hs_width: got %0d want 96", low_cnt);
    end
    n_cmp++;
    if (first_low != 656 || first_high != 752) begin
      n_fail++; $display("FAIL hs_edges: got low@%0d high@%0d want low@656 high@752", first_low, first_high);
    end
  endtask

  task automatic test_vsync();
    int ht = TB.h_vis + TB.h_fp + TB.h_sync + TB.h_bp;
    int vt = TB.v_vis + TB.v_fp + TB.v_sync + TB.v_bp;
    int low_cnt = 0, blank_late = 0, budget = 0;
    int fx = -1, fy = -1, lx = -1, ly = -1;
    while (fs_b !== 1'b1 && budget < 2000) begin
      @(negedge vga_clk);
      budget++;
    end
    for (int i = 0; i < ht * vt; i++) begin
      n_cmp++;
      if (obs_b !== model(t, TB)) begin
        n_fail++; $display("FAIL vsync_model: got %s want %s", fmt(obs_b), fmt(model(t, TB)));
      end
      if (vs_b === 1'b0) begin
        low_cnt++;
        if (fx < 0) begin fx = int'(x_b); fy = int'(y_b); end
        lx = int'(x_b); ly = int'(y_b);
      end
      if (int'(y_b) >= TB.v_vis && bl_b !== 1'b0) blank_late++;
      @(negedge vga_clk);
    end
    n_cmp++;
    if (low_cnt != TB.v_sync * ht) begin
      n_fail++; $display("FAIL vs_width: got %0d want %0d", low_cnt, TB.v_sync * ht);
    end
    n_cmp++;
    if (fx != 0 || fy != TB.v_vis + TB.v_fp || lx != ht - 1 || ly != TB.v_vis + TB.v_fp + TB.v_sync - 1) begin
      n_fail++; $display("FAIL vs_span: got (%0d,%0d)..(%0d,%0d) want (0,%0d)..(%0d,%0d)", fx, fy, lx, ly,
                         TB.v_vis + TB.v_fp, ht - 1, TB.v_vis + TB.v_fp + TB.v_sync - 1);
    end
    n_cmp++;
    if (blank_late != 0) begin
      n_fail++; $display("FAIL blank_vertical: got %0d active cycles in blanking lines want 0", blank_late);
    end
  endtask

  task automatic test_frame_length();
    int frame = (TB.h_vis + TB.h_fp + TB.h_sync + TB.h_bp) * (TB.v_vis + TB.v_fp + TB.v_sync + TB.v_bp);
    int budget = 0;
    while (fs_b !== 1'b1 && budget < 2000) begin
      @(negedge vga_clk);
      budget++;
    end
    for (int f = 0; f < 3; f++) begin
      int len = 0, act = 0;
      do begin
        if (bl_b === 1'b1) act++;
        @(negedge vga_clk);
        len++;
      end while (fs_b !== 1'b1 && len < 2 * frame);
      n_cmp++;
      if (len != frame) begin
        n_fail++; $display("FAIL frame_period[%0d]: got %0d want %0d", f, len, frame);
      end
      n_cmp++;
      if (act != TB.h_vis * TB.v_vis) begin
        n_fail++; $display("FAIL active_count[%0d]: got %0d want %0d", f, act, TB.h_vis * TB.v_vis);
      end
    end
  endtask

  task automatic test_delay_line();
    int span = int'($urandom_range(500, 1500));
    for (int i = 0; i < span; i++) begin
      view_t ea, eb, ec;
      @(negedge vga_clk);
      ea = model(t, TA); eb = model(t, TB); ec = model(t, TC);
      n_cmp++;
      if ({hsd_a, vsd_a, bld_a} !== {ea.hs_d, ea.vs_d, ea.blank_d} ||
          {hsd_b, vsd_b, bld_b} !== {eb.hs_d, eb.vs_d, eb.blank_d} ||
          {hsd_c, vsd_c, bld_c} !== {ec.hs_d, ec.vs_d, ec.blank_d}) begin
        n_fail++; $display("FAIL delay_line: got a=%b%b%b b=%b%b%b c=%b%b%b want a=%b%b%b b=%b%b%b c=%b%b%b",
                           hsd_a, vsd_a, bld_a, hsd_b, vsd_b, bld_b, hsd_c, vsd_c, bld_c,
                           ea.hs_d, ea.vs_d, ea.blank_d, eb.hs_d, eb.vs_d, eb.blank_d,
                           ec.hs_d, ec.vs_d, ec.blank_d);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    int budget = 0;
    int hold = int'($urandom_range(1, 4));
    while (x_a != 10'd300 && budget < 1000) begin
      @(negedge vga_clk);
      budget++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (x_a !== 10'd799 || y_a !== 10'd524 || hs_a !== 1'b1 || vs_a !== 1'b1 || bl_a !== 1'b0 ||
        fs_a !== 1'b0 || ls_a !== 1'b0 || hsd_a !== 1'b1 || vsd_a !== 1'b1 || bld_a !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_a: got %s want reset state", fmt(obs_a));
    end
    n_cmp++;
    if (obs_b !== model(-1, TB) || obs_c !== model(-1, TC)) begin
      n_fail++; $display("FAIL async_reset_bc: got %s / %s want %s", fmt(obs_b), fmt(obs_c), fmt(model(-1, TB)));
    end
    repeat (hold) @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
    n_cmp++;
    if (x_a !== 10'd0 || y_a !== 10'd0 || fs_a !== 1'b1 || obs_a !== model(t, TA)) begin
      n_fail++; $display("FAIL restart_a: got %s want %s", fmt(obs_a), fmt(model(t, TA)));
    end
  endtask

  task automatic test_random_sweep();
    for (int it = 0; it < 6; it++) begin
      int run = int'($urandom_range(200, 2500));
      for (int i = 0; i < run; i++) begin
        @(negedge vga_clk);
        n_cmp++;
        if (obs_a !== model(t, TA) || obs_b !== model(t, TB) || obs_c !== model(t, TC)) begin
          n_fail++; $display("FAIL sweep[%0d]: t=%0d got %s | %s | %s want %s | %s | %s", it, t,
                             fmt(obs_a), fmt(obs_b), fmt(obs_c),
                             fmt(model(t, TA)), fmt(model(t, TB)), fmt(model(t, TC)));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        #($urandom_range(1, 3)) reset_n = 1'b0;
        repeat (int'($urandom_range(1, 3))) @(negedge vga_clk);
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line_wrap();
    test_hsync();
    test_vsync();
    test_frame_length();
    test_delay_line();
    test_mid_frame_reset();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
